// File: rtl/synth_pkg.sv
// Shared constants, command-word layout and parser state type for the MIDI command writer.
package synth_pkg;

  localparam int unsigned CMD_W        = 32;
  localparam int unsigned CMD_VEL_LSB  = 0;
  localparam int unsigned CMD_VEL_W    = 8;
  localparam int unsigned CMD_NOTE_LSB = 8;
  localparam int unsigned CMD_NOTE_W   = 7;
  localparam int unsigned CMD_ON_BIT   = 15;

  localparam logic [CMD_W-1:0] CMD_STOP_ALL    = 32'h0000_7F00;
  localparam logic [CMD_W-1:0] CMD_WAVE_SWITCH = 32'h0000_8000;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_POLY_AT  = 4'hA;
  localparam logic [3:0] MIDI_CC       = 4'hB;
  localparam logic [3:0] MIDI_PROG     = 4'hC;
  localparam logic [3:0] MIDI_CHAN_AT  = 4'hD;
  localparam logic [3:0] MIDI_PITCH    = 4'hE;

  localparam logic [7:0] MIDI_SYS_MIN      = 8'hF0;
  localparam logic [7:0] MIDI_SYSEX_START  = 8'hF0;
  localparam logic [7:0] MIDI_SYSEX_END    = 8'hF7;
  localparam logic [7:0] MIDI_REALTIME_MIN = 8'hF8;

  localparam logic [6:0] MIDI_CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA1,
    ST_DATA2,
    ST_SKIP,
    ST_SYSEX
  } parser_state_e;

  function automatic logic [CMD_W-1:0] note_word(input logic on,
                                                 input logic [CMD_NOTE_W-1:0] note,
                                                 input logic [CMD_VEL_W-1:0] vel);
    logic [CMD_W-1:0] w;
    w = '0;
    w[CMD_ON_BIT] = on;
    w[CMD_NOTE_LSB +: CMD_NOTE_W] = note;
    w[CMD_VEL_LSB +: CMD_VEL_W] = vel;
    return w;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Power-of-two command FIFO with registered full/empty flags and occupancy level.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (pop_ok)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = LVL_W'(level_q + 1'b1);
      2'b01:   level_d = LVL_W'(level_q - 1'b1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_W'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/midi_cmd_writer.sv
// MIDI byte-stream parser that turns note/CC/program messages into 32-bit
// synth commands and writes them out over an Avalon-MM master via a FIFO.
module midi_cmd_writer
  import synth_pkg::*;
#(
  parameter int unsigned MIDI_CHANNEL   = 0,
  parameter int unsigned CHANNEL_FILTER = 0,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    asi_data,
  input  logic                          asi_valid,
  output logic                          asi_ready,
  output logic                          avm_m0_write,
  output logic [31:0]                   avm_m0_writedata,
  input  logic                          avm_m0_waitrequest,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  parser_state_e          state_q, state_d;
  logic [7:0]             status_q, status_d;
  logic [CMD_NOTE_W-1:0]  note_q, note_d;
  logic                   push_c;
  logic [CMD_W-1:0]       push_word_c;

  logic                   accept;
  logic                   is_status;
  logic                   is_realtime;
  logic [3:0]             msg;
  logic                   chan_ok;
  logic                   one_byte_msg;
  logic                   note_msg;
  logic                   fifo_full, fifo_empty, fifo_pop;

  assign accept       = asi_valid && asi_ready;
  assign is_status    = asi_data[7];
  assign is_realtime  = (asi_data >= MIDI_REALTIME_MIN);
  assign msg          = status_q[7:4];
  assign chan_ok      = (CHANNEL_FILTER == 0) || (status_q[3:0] == 4'(MIDI_CHANNEL));
  assign one_byte_msg = (msg == MIDI_PROG) || (msg == MIDI_CHAN_AT);
  assign note_msg     = (msg == MIDI_NOTE_OFF) || (msg == MIDI_NOTE_ON);

  // Parser next-state: status bytes are handled uniformly in every state,
  // which also terminates SysEx and abandons any partial message.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    note_d      = note_q;
    push_c      = 1'b0;
    push_word_c = '0;
    if (accept && !is_realtime) begin
      if (is_status) begin
        if (asi_data < MIDI_SYS_MIN) begin
          status_d = asi_data;
          state_d  = ST_DATA1;
        end else if (asi_data == MIDI_SYSEX_START) begin
          state_d  = ST_SYSEX;
        end else begin
          status_d = '0;
          state_d  = ST_IDLE;
        end
      end else begin
        unique case (state_q)
          ST_IDLE, ST_DATA1: begin
            // status_q[7] is clear only when no running status is held.
            if (status_q[7]) begin
              if (one_byte_msg) begin
                state_d = ST_DATA1;
                if (msg == MIDI_PROG && chan_ok) begin
                  push_c      = 1'b1;
                  push_word_c = CMD_WAVE_SWITCH;
                end
              end else begin
                note_d = asi_data[6:0];
                if (chan_ok && (note_msg ||
                    (msg == MIDI_CC && asi_data[6:0] == MIDI_CC_ALL_NOTES_OFF)))
                  state_d = ST_DATA2;
                else
                  state_d = ST_SKIP;
              end
            end
          end
          ST_DATA2: begin
            state_d = ST_DATA1;
            push_c  = 1'b1;
            if (msg == MIDI_CC)
              push_word_c = CMD_STOP_ALL;
            else
              push_word_c = note_word((msg == MIDI_NOTE_ON) && (asi_data != 8'h00),
                                      note_q, asi_data);
          end
          ST_SKIP:  state_d = ST_DATA1;
          ST_SYSEX: state_d = ST_SYSEX;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      status_q <= '0;
      note_q   <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      note_q   <= note_d;
    end
  end

  assign fifo_pop = !fifo_empty && !avm_m0_waitrequest;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push_c),
    .data_i  (push_word_c),
    .pop_i   (fifo_pop),
    .data_o  (avm_m0_writedata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_fifo_level)
  );

  assign asi_ready    = !fifo_full;
  assign avm_m0_write = !fifo_empty;

endmodule

// File: tb/tb_midi_cmd_writer.sv
// Scoreboard bench for midi_cmd_writer: expected words are queued as stimulus
// is driven and compared in order as the Avalon master completes writes.
module tb_midi_cmd_writer;

  localparam int unsigned DEPTH = 4;

  logic                     clk;
  logic                     reset;
  logic [7:0]               asi_data;
  logic                     asi_valid;
  logic                     asi_ready;
  logic                     avm_m0_write;
  logic [31:0]              avm_m0_writedata;
  logic                     avm_m0_waitrequest;
  logic [$clog2(DEPTH):0]   o_fifo_level;

  midi_cmd_writer #(
    .MIDI_CHANNEL   (0),
    .CHANNEL_FILTER (0),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .asi_data           (asi_data),
    .asi_valid          (asi_valid),
    .asi_ready          (asi_ready),
    .avm_m0_write       (avm_m0_write),
    .avm_m0_writedata   (avm_m0_writedata),
    .avm_m0_waitrequest (avm_m0_waitrequest),
    .o_fifo_level       (o_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_count = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] nw(input bit on, input int note, input int vel);
    return {16'h0000, on, note[6:0], vel[7:0]};
  endfunction

  // Every completed transfer is checked against the oldest expected word.
  always @(negedge clk) begin
    if (reset && avm_m0_write && !avm_m0_waitrequest) begin
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("sb_word", avm_m0_writedata, e);
      wr_count++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    asi_data  = b;
    asi_valid = 1'b1;
    @(negedge clk);
    while (!asi_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!asi_ready) check("ready_timeout", 32'(asi_ready), 32'd1);
    @(posedge clk);
    #1 asi_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s [$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((avm_m0_write || exp_q.size() > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_level"}, 32'(o_fifo_level), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [7:0] seq [$];
    logic [31:0] head;

    reset = 1'b0;
    asi_data = '0;
    asi_valid = 1'b0;
    avm_m0_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(asi_ready), 32'd1);
    check("rst_write", 32'(avm_m0_write), 32'd0);
    check("rst_wdata", avm_m0_writedata, 32'd0);
    check("rst_level", 32'(o_fifo_level), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single note-on, write exactly one cycle after the last byte.
    exp_q.push_back(32'h0000_C564);
    send_byte(8'h90);
    send_byte(8'h45);
    @(negedge clk);
    check("t36_no_early_write", 32'(avm_m0_write), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h64);
    @(negedge clk);
    check("t36_latency", 32'(avm_m0_write), 32'd1);
    check("t36_word", avm_m0_writedata, 32'h0000_C564);
    @(posedge clk);
    #1;
    drain("t36");

    // Running status with velocity-0 note-on.
    exp_q.push_back(32'h0000_C564);
    exp_q.push_back(32'h0000_4500);
    seq = '{8'h90, 8'h45, 8'h64, 8'h45, 8'h00};
    send_seq(seq);
    drain("t37");

    // Program change, CC 123 and an ignored controller.
    base = wr_count;
    exp_q.push_back(32'h0000_8000);
    exp_q.push_back(32'h0000_7F00);
    seq = '{8'hC0, 8'h05, 8'hB0, 8'h7B, 8'h00, 8'hB0, 8'h07, 8'h40};
    send_seq(seq);
    drain("t38");
    check("t38_nwrites", 32'(wr_count - base), 32'd2);

    // Messages that push nothing, then note-off variants and running program change.
    base = wr_count;
    exp_q.push_back(nw(0, 8'h7F, 8'h40));
    exp_q.push_back(32'h0000_7F00);
    exp_q.push_back(32'h0000_8000);
    exp_q.push_back(32'h0000_8000);
    exp_q.push_back(nw(1, 8'h30, 8'h50));
    exp_q.push_back(nw(1, 8'h20, 8'h01));
    seq = '{8'hA0, 8'h10, 8'h20, 8'hD0, 8'h33, 8'hE0, 8'h00, 8'h40,
            8'h80, 8'h7F, 8'h40, 8'h7F, 8'h00,
            8'hC0, 8'h05, 8'h09,
            8'h90, 8'h30, 8'hFE, 8'h50,
            8'h93, 8'h20, 8'h01};
    send_seq(seq);
    drain("misc");
    check("misc_nwrites", 32'(wr_count - base), 32'd6);

    // Real-time and SysEx interleaving yields nothing.
    base = wr_count;
    seq = '{8'h90, 8'hF8, 8'h3C, 8'hF0, 8'h01, 8'hF7, 8'h3C, 8'h7F};
    send_seq(seq);
    repeat (5) @(negedge clk);
    check("t40_nwrites", 32'(wr_count - base), 32'd0);
    @(posedge clk);
    #1;

    // Back-pressure: six note-ons with the slave stalled.
    base = wr_count;
    avm_m0_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(nw(1, 8'h40 + i, 8'h10 + i));
    send_byte(8'h90);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(8'h40 + i));
      send_byte(8'(8'h10 + i));
    end
    @(negedge clk);
    check("t39_ready_low", 32'(asi_ready), 32'd0);
    check("t39_level", 32'(o_fifo_level), 32'(DEPTH));
    head = nw(1, 8'h40, 8'h10);
    check("t39_head", avm_m0_writedata, head);
    fork
      begin
        for (int i = 4; i < 6; i++) begin
          send_byte(8'(8'h40 + i));
          send_byte(8'(8'h10 + i));
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("t39_stable", avm_m0_writedata, head);
        end
        @(posedge clk);
        #1 avm_m0_waitrequest = 1'b0;
      end
    join
    drain("t39");
    check("t39_nwrites", 32'(wr_count - base), 32'd6);

    // Reset with queued commands and a partial message in flight.
    avm_m0_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(nw(1, 8'h50 + i, 8'h20));
    send_byte(8'h90);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h50 + i));
      send_byte(8'h20);
    end
    send_byte(8'h45);
    @(negedge clk);
    check("t41_pre_level", 32'(o_fifo_level), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("t41_write", 32'(avm_m0_write), 32'd0);
    check("t41_level", 32'(o_fifo_level), 32'd0);
    check("t41_wdata", avm_m0_writedata, 32'd0);
    check("t41_ready", 32'(asi_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    avm_m0_waitrequest = 1'b0;
    base = wr_count;
    send_byte(8'h64);
    send_byte(8'h45);
    send_byte(8'h64);
    repeat (5) @(negedge clk);
    check("t41_nwrites", 32'(wr_count - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
